axi_stream_video_monitor: RTL and testbench

Parametrised AXI-Stream video sink and protocol monitor, the next generation of the beat/frame-counting sink stub used behind the video pipeline in simulation and on-chip bring-up. Accepts a raster stream (tuser = SOF on the first pixel, tlast = EOL on the last pixel of each line), checks it against a fixed geometry, and generates programmable back-pressure. Reports beat, line, frame, error and discard counts, plus a per-frame data sum.

---
 rtl/axi_stream_video_monitor.sv | 106 ++++++++++
 tb/tb_axi_stream_video_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_video_monitor.sv
// axi_stream_video_monitor: AXI-Stream raster sink that checks frame geometry,
// counts beats/lines/frames/errors and generates programmable back-pressure.
module axi_stream_video_monitor #(
  parameter int DATA_WIDTH = 24,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  input  logic [1:0]            ready_mode,
  input  logic [7:0]            stall_period,
  input  logic                  clr_errs,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  line_count,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  bad_frame_count,
  output logic [CNT_WIDTH-1:0]  discard_count,
  output logic [3:0]            err_flags,
  output logic [15:0]           last_line_len,
  output logic [31:0]           frame_sum,
  output logic                  frame_done
);
  typedef enum logic {WAIT_SOF, IN_FRAME} state_t;
  localparam logic [31:0] H = 32'(H_ACTIVE);
  localparam logic [31:0] V = 32'(V_ACTIVE);
  state_t state;
  logic [15:0] px, e_px;
  logic [16:0] px1;
  logic [31:0] ln, e_ln, sum, e_sum;
  logic ferr, e_ferr, acc, sof, active, abort, short_l, long_l, done, bad_done, rdy_next;
  logic [3:0] ev;
  logic [7:0] stall_cnt;
  logic [15:0] lfsr;
  assign acc = s_axis_tvalid && s_axis_tready;
  // An SOF beat restarts the frame context, so every in-frame rule sees it as px=0, ln=0.
  always_comb begin
    sof = acc && s_axis_tuser;
    active = acc && (sof || state == IN_FRAME);
    abort = sof && state == IN_FRAME;
    e_px = sof ? 16'd0 : px;
    e_ln = sof ? 32'd0 : ln;
    e_sum = (sof ? 32'd0 : sum) + 32'(s_axis_tdata);
    e_ferr = !sof && ferr;
    px1 = {1'b0, e_px} + 17'd1;
    short_l = active && s_axis_tlast && 32'(px1) < H;
    long_l = active && !s_axis_tlast && 32'(e_px) >= H - 32'd1;
    done = active && s_axis_tlast && e_ln == V - 32'd1;
    bad_done = done && (e_ferr || short_l || long_l);
    ev = {acc && !s_axis_tuser && state == WAIT_SOF, abort, long_l, short_l};
    rdy_next = ready_mode == 2'd0 ? 1'b1 :
               ready_mode == 2'd1 ? (stall_period < 8'd2 || stall_cnt != stall_period - 8'd1) :
               ready_mode == 2'd2 ? (lfsr[0] | lfsr[1]) : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_SOF;
      px <= '0;
      ln <= '0;
      sum <= '0;
      ferr <= 1'b0;
      stall_cnt <= '0;
      lfsr <= 16'hACE1;
      s_axis_tready <= 1'b0;
      beat_count <= '0;
      line_count <= '0;
      frame_count <= '0;
      bad_frame_count <= '0;
      discard_count <= '0;
      err_flags <= '0;
      last_line_len <= '0;
      frame_sum <= '0;
      frame_done <= 1'b0;
    end else begin
      s_axis_tready <= rdy_next;
      stall_cnt <= (stall_period < 8'd2 || stall_cnt >= stall_period - 8'd1) ? 8'd0 : stall_cnt + 8'd1;
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      frame_done <= done;
      err_flags <= (clr_errs ? 4'd0 : err_flags) | ev;
      beat_count <= beat_count + CNT_WIDTH'(acc);
      line_count <= line_count + CNT_WIDTH'(active && s_axis_tlast);
      discard_count <= discard_count + CNT_WIDTH'(ev[3]);
      frame_count <= frame_count + CNT_WIDTH'(done);
      bad_frame_count <= bad_frame_count + CNT_WIDTH'(abort) + CNT_WIDTH'(bad_done);
      if (active) begin
        if (s_axis_tlast) begin
          last_line_len <= px1[16] ? 16'hFFFF : px1[15:0];
          px <= '0;
          ln <= e_ln + 32'd1;
        end else begin
          px <= px1[16] ? 16'hFFFF : px1[15:0];
          ln <= e_ln;
        end
        sum <= e_sum;
        ferr <= e_ferr || short_l || long_l;
        state <= done ? WAIT_SOF : IN_FRAME;
        if (done) frame_sum <= e_sum;
      end
    end
  end
endmodule

// File: tb/tb_axi_stream_video_monitor.sv
// tb_axi_stream_video_monitor: directed and randomized checks of the video monitor
// against a frame-level reference model.
module tb_axi_stream_video_monitor;
  localparam int H = 4;
  localparam int V = 3;
  logic clk = 0;
  logic rst = 1;
  logic [23:0] s_axis_tdata = 0;
  logic s_axis_tvalid = 0, s_axis_tlast = 0, s_axis_tuser = 0, s_axis_tready;
  logic [1:0] ready_mode = 0;
  logic [7:0] stall_period = 0;
  logic clr_errs = 0;
  logic [31:0] beat_count, line_count, frame_count, bad_frame_count, discard_count, frame_sum;
  logic [3:0] err_flags;
  logic [15:0] last_line_len;
  logic frame_done;
  int checks = 0, errors = 0;
  string cur = "init";
  bit m_in, m_ferr, m_done;
  int m_px, m_ln;
  bit [31:0] m_sum, m_fsum, m_beat, m_line, m_frame, m_bad, m_disc, m_len;
  bit [3:0] m_err;

  axi_stream_video_monitor #(.DATA_WIDTH(24), .H_ACTIVE(H), .V_ACTIVE(V), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
    .ready_mode(ready_mode), .stall_period(stall_period), .clr_errs(clr_errs),
    .beat_count(beat_count), .line_count(line_count), .frame_count(frame_count),
    .bad_frame_count(bad_frame_count), .discard_count(discard_count), .err_flags(err_flags),
    .last_line_len(last_line_len), .frame_sum(frame_sum), .frame_done(frame_done));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", cur, name, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("beat", beat_count, m_beat);
    chk("line", line_count, m_line);
    chk("frame", frame_count, m_frame);
    chk("bad", bad_frame_count, m_bad);
    chk("discard", discard_count, m_disc);
    chk("err", 32'(err_flags), 32'(m_err));
    chk("len", 32'(last_line_len), m_len);
    chk("fsum", frame_sum, m_fsum);
    chk("done", 32'(frame_done), 32'(m_done));
  endtask

  task automatic model_clear();
    m_in = 0; m_ferr = 0; m_done = 0; m_px = 0; m_ln = 0;
    m_sum = 0; m_fsum = 0; m_beat = 0; m_line = 0; m_frame = 0;
    m_bad = 0; m_disc = 0; m_len = 0; m_err = 0;
  endtask

  // Behaviour of one accepted beat, straight from the raster rules.
  task automatic model(input bit [23:0] d, input bit l, input bit u);
    m_beat++;
    if (!m_in && !u) begin
      m_disc++;
      m_err[3] = 1;
      return;
    end
    if (u) begin
      if (m_in) begin
        m_err[2] = 1;
        m_bad++;
      end
      m_in = 1; m_px = 0; m_ln = 0; m_sum = 0; m_ferr = 0;
    end
    m_sum += 32'(d);
    if (l) begin
      m_line++;
      m_len = (m_px + 1 > 65535) ? 32'd65535 : 32'(m_px + 1);
      if (m_px + 1 < H) begin
        m_err[0] = 1;
        m_ferr = 1;
      end
      if (m_ln == V - 1) begin
        m_frame++;
        m_fsum = m_sum;
        m_done = 1;
        if (m_ferr) m_bad++;
        m_in = 0;
      end else begin
        m_px = 0;
        m_ln++;
      end
    end else begin
      if (m_px >= H - 1) begin
        m_err[1] = 1;
        m_ferr = 1;
      end
      m_px++;
    end
  endtask

  task automatic beat(input bit v, input bit [23:0] d, input bit l, input bit u, input bit clr, output bit acc);
    s_axis_tvalid = v; s_axis_tdata = d; s_axis_tlast = l; s_axis_tuser = u; clr_errs = clr;
    m_done = 0;
    @(negedge clk);
    acc = v && s_axis_tready === 1'b1;
    if (clr) m_err = 0;
    if (acc) model(d, l, u);
    @(posedge clk); #1;
    s_axis_tvalid = 0; clr_errs = 0;
    check_all();
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) beat(0, 0, 0, 0, 0, a);
  endtask

  task automatic send(input bit rnd, input bit [23:0] d, input bit l, input bit u);
    bit a = 0;
    int n = 0;
    while (!a && n < 200) begin
      beat(rnd ? $urandom_range(0, 3) != 0 : 1'b1, d, l, u, rnd && $urandom_range(0, 15) == 0, a);
      n++;
    end
    checks++;
    assert (a) else begin
      errors++;
      $error("FAIL %s.send_timeout observed=%0d expected=accept", cur, n);
    end
  endtask

  task automatic clean_frame(input bit rnd, input int base);
    for (int i = 0; i < H * V; i++) send(rnd, 24'(base + i), (i % H) == H - 1, i == 0);
  endtask

  task automatic do_reset(input string t);
    cur = t; rst = 1; s_axis_tvalid = 0;
    @(posedge clk); #1;
    model_clear();
    check_all();
    chk("tready_in_rst", 32'(s_axis_tready), 0);
    rst = 0;
    @(posedge clk); #1;
    chk("tready_after_rst", 32'(s_axis_tready), 1);
  endtask

  initial begin
    int lows;
    bit a;
    do_reset("clean");
    clean_frame(0, 1);
    chk("beat12", beat_count, 12);
    chk("line3", line_count, 3);
    chk("frame1", frame_count, 1);
    chk("fsum78", frame_sum, 78);
    chk("len4", 32'(last_line_len), 4);
    chk("done_pulse", 32'(frame_done), 1);
    idle(1);
    chk("done_low", 32'(frame_done), 0);

    do_reset("nosof");
    for (int i = 0; i < 3; i++) send(0, 24'(100 + i), 0, 0);
    clean_frame(0, 1);
    chk("discard3", discard_count, 3);
    chk("err8", 32'(err_flags), 8);
    chk("bad0", bad_frame_count, 0);
    beat(0, 0, 0, 0, 1, a);
    chk("cleared", 32'(err_flags), 0);

    do_reset("shortlong");
    for (int i = 0; i < 4; i++) send(0, 24'(i), i == 3, i == 0);
    for (int i = 0; i < 2; i++) send(0, 24'(i), i == 1, 0);
    for (int i = 0; i < 6; i++) send(0, 24'(i), i == 5, 0);
    chk("err3", 32'(err_flags), 3);
    chk("len6", 32'(last_line_len), 6);
    chk("frame1", frame_count, 1);
    chk("bad1", bad_frame_count, 1);

    do_reset("earlysof");
    for (int i = 0; i < 4; i++) send(0, 24'(i), i == 3, i == 0);
    for (int i = 0; i < 2; i++) send(0, 24'(i), 0, 0);
    clean_frame(0, 7);
    chk("err4", 32'(err_flags), 4);
    chk("bad1", bad_frame_count, 1);
    chk("frame1", frame_count, 1);

    do_reset("stall");
    ready_mode = 1; stall_period = 4;
    idle(3);
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      beat(1, 24'(i), 0, 0, 0, a);
      if (!a) lows++;
    end
    chk("lows10", 32'(lows), 10);
    chk("beat30", beat_count, 30);
    ready_mode = 3;
    idle(1);
    for (int i = 0; i < 20; i++) begin
      beat(1, 24'(i), 0, 0, 0, a);
      chk("tready_never", 32'(s_axis_tready), 0);
    end
    chk("beat_held", beat_count, 30);
    ready_mode = 0;

    do_reset("midreset");
    for (int i = 0; i < 6; i++) send(0, 24'(i), i == 3, i == 0);
    do_reset("midreset_after");
    clean_frame(0, 3);
    chk("frame1", frame_count, 1);

    do_reset("random");
    ready_mode = 2;
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 4) == 0) send(1, 24'($urandom), 0, 0);
      for (int l = 0; l < V; l++) begin
        int len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : H;
        for (int p = 0; p < len; p++)
          send(1, 24'($urandom), p == len - 1, (l == 0 && p == 0) || $urandom_range(0, 59) == 0);
      end
      idle($urandom_range(0, 2));
    end
    chk("random_frames_seen", 32'(frame_count != 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
